// File: rtl/ula_sequencer.sv
// ---------------------------------------------------------------------------
// ula_sequencer
//   Single-issue instruction sequencer driving an external combinational ULA.
//   It holds a 4x8 register file and moves through IDLE -> ISSUE -> DONE for
//   ALU operations, or IDLE -> DONE for LOADI and invalid opcodes.
//
//   Instruction word: [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2,
//                     [7:0] imm (LOADI only).
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     in_valid/in_instr instruction offered by the source
//     in_ready          high only in IDLE; the source must hold until accepted
//     ula_operation     opcode to ULA (0 outside ISSUE)
//     operand1/2        ULA operands (0 outside ISSUE; operand2=0 for NOT)
//     ula_result/flags  combinational ULA outputs, captured at end of ISSUE
//     done              one-cycle completion pulse (DONE state)
//     err               sticky error, cleared on the next accept
//     flags_q           flags from the last executed ULA operation
//     dbg_sel/dbg_data  combinational register-file read port
//
//   Build option
//     ULA_SEQ_DIV0_TRAP_EN : DIV/MOD whose rs2 value is zero is not issued;
//                            err is raised and nothing is written back.
// ---------------------------------------------------------------------------
module ula_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [3:0]  ula_operation,
    output logic [7:0]  operand1,
    output logic [7:0]  operand2,
    input  logic [7:0]  ula_result,
    input  logic [7:0]  ula_flags,
    output logic        done,
    output logic        err,
    output logic [7:0]  flags_q,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned REG_N  = 4;

    localparam logic [OP_W-1:0] OP_LOADI = 4'b0000;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0100;
    localparam logic [OP_W-1:0] OP_MOD   = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [IDX_W-1:0]        rd_q, rd_d;
    logic [DATA_W-1:0]       opa_q, opa_d;
    logic [DATA_W-1:0]       opb_q, opb_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       flags_d;
    logic [DATA_W-1:0]       rf_q [REG_N];
    logic [DATA_W-1:0]       rf_d [REG_N];

    // Instruction field decode
    logic [OP_W-1:0]         instr_op_c;
    logic [IDX_W-1:0]        instr_rd_c;
    logic [IDX_W-1:0]        instr_rs1_c;
    logic [IDX_W-1:0]        instr_rs2_c;
    logic [DATA_W-1:0]       instr_imm_c;
    logic [DATA_W-1:0]       rs1_val_c;
    logic [DATA_W-1:0]       rs2_val_c;
    logic                    div0_trap_c;

    assign instr_op_c  = in_instr[15:12];
    assign instr_rd_c  = in_instr[11:10];
    assign instr_rs1_c = in_instr[9:8];
    assign instr_rs2_c = in_instr[7:6];
    assign instr_imm_c = in_instr[7:0];
    assign rs1_val_c   = rf_q[instr_rs1_c];
    assign rs2_val_c   = rf_q[instr_rs2_c];

    // Divide-by-zero trap qualifier (constant 0 when the trap is not built)
`ifdef ULA_SEQ_DIV0_TRAP_EN
    assign div0_trap_c = ((instr_op_c == OP_DIV) || (instr_op_c == OP_MOD)) &&
                         (rs2_val_c == DATA_W'(0));
`else
    assign div0_trap_c = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        err_d   = err_q;
        flags_d = flags_q;
        for (int i = 0; i < REG_N; i++) begin
            rf_d[i] = rf_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Accept: error from the previous instruction is dropped first
                    err_d = 1'b0;
                    op_d  = instr_op_c;
                    rd_d  = instr_rd_c;
                    opa_d = rs1_val_c;
                    // NOT is unary; its second operand is forced to zero
                    opb_d = (instr_op_c == OP_NOT) ? DATA_W'(0) : rs2_val_c;
                    if (instr_op_c == OP_LOADI) begin
                        rf_d[instr_rd_c] = instr_imm_c;
                        state_d          = S_DONE;
                    end else if (instr_op_c <= OP_NOT) begin
                        if (div0_trap_c) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                rf_d[rd_q] = ula_result;
                flags_d    = ula_flags;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOADI;
            rd_q    <= IDX_W'(0);
            opa_q   <= DATA_W'(0);
            opb_q   <= DATA_W'(0);
            err_q   <= 1'b0;
            flags_q <= DATA_W'(0);
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= DATA_W'(0);
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // ULA drive: latched operation only while in ISSUE, quiet otherwise
    always_comb begin
        ula_operation = OP_LOADI;
        operand1      = DATA_W'(0);
        operand2      = DATA_W'(0);
        if (state_q == S_ISSUE) begin
            ula_operation = op_q;
            operand1      = opa_q;
            operand2      = opb_q;
        end
    end

    // Status decoded directly from state register
    assign in_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_ula_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ula_sequencer
//   Directed bench for ula_sequencer with a behavioural ULA model.
//   Model: ADD/SUB/MUL truncated to 8 bits, DIV by 0 -> 0xFF, MOD by 0 -> a,
//   NOT = ~a; flags = {res[7], res==0, 2'b00, op}.
// ---------------------------------------------------------------------------
module tb_ula_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [3:0]  ula_operation;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [7:0]  ula_result;
    logic [7:0]  ula_flags;
    logic        done;
    logic        err;
    logic [7:0]  flags_q;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    ula_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .ula_operation (ula_operation),
        .operand1      (operand1),
        .operand2      (operand2),
        .ula_result    (ula_result),
        .ula_flags     (ula_flags),
        .done          (done),
        .err           (err),
        .flags_q       (flags_q),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA
    always_comb begin
        logic [7:0] r;
        case (ula_operation)
            4'd1:    r = operand1 + operand2;
            4'd2:    r = operand1 - operand2;
            4'd3:    r = 8'(operand1 * operand2);
            4'd4:    r = (operand2 == 8'd0) ? 8'hFF : operand1 / operand2;
            4'd5:    r = (operand2 == 8'd0) ? operand1 : operand1 % operand2;
            4'd6:    r = operand1 & operand2;
            4'd7:    r = operand1 | operand2;
            4'd8:    r = operand1 ^ operand2;
            4'd9:    r = ~operand1;
            default: r = 8'd0;
        endcase
        ula_result = r;
        ula_flags  = {r[7], (r == 8'd0), 2'b00, ula_operation};
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rf_chk(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    // Offer one instruction at a negedge; returns at the negedge after accept
    task automatic send(input logic [15:0] instr);
        int n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] stream [3];
        int base;
        int n;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_sel  = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'h00);
        chk("rst_ulaop", 32'(ula_operation), 32'd0);
        chk("rst_op1", 32'(operand1), 32'd0);
        chk("rst_op2", 32'(operand2), 32'd0);
        for (int i = 0; i < 4; i++) rf_chk("rst_rf", 2'(i), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(in_ready), 32'd1);

        // LOADI r0=0x05: done in N+1
        send(16'h0005);
        chk("ldi_done", 32'(done), 32'd1);
        chk("ldi_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ldi_done_end", 32'(done), 32'd0);
        rf_chk("ldi_r0", 2'd0, 8'h05);

        // LOADI r1=0x06
        send(16'h0406);
        chk("ldi1_done", 32'(done), 32'd1);
        @(negedge clk);
        rf_chk("ldi_r1", 2'd1, 8'h06);

        // ADD r2,r0,r1: ISSUE N+1, done N+2, ready N+3
        send(16'h1840);
        chk("add_issue_done", 32'(done), 32'd0);
        chk("add_op", 32'(ula_operation), 32'd1);
        chk("add_a", 32'(operand1), 32'h05);
        chk("add_b", 32'(operand2), 32'h06);
        @(negedge clk);
        chk("add_done", 32'(done), 32'd1);
        chk("add_op_idle", 32'(ula_operation), 32'd0);
        @(negedge clk);
        chk("add_done_end", 32'(done), 32'd0);
        chk("add_ready", 32'(in_ready), 32'd1);
        rf_chk("add_r2", 2'd2, 8'h0B);
        chk("add_flags", 32'(flags_q), 32'h01);

        // SUB r3,r2,r0 with r2=0x0C
        send(16'h080C);
        @(negedge clk);
        send(16'h2E00);
        chk("sub_op", 32'(ula_operation), 32'd2);
        chk("sub_a", 32'(operand1), 32'h0C);
        chk("sub_b", 32'(operand2), 32'h05);
        @(negedge clk);
        chk("sub_done", 32'(done), 32'd1);
        @(negedge clk);
        rf_chk("sub_r3", 2'd3, 8'h07);
        chk("sub_flags", 32'(flags_q), 32'h02);

        // NOT r3,r3 (rs2 field = r1, operand2 must still be zero)
        send(16'h9F40);
        chk("not_op", 32'(ula_operation), 32'd9);
        chk("not_a", 32'(operand1), 32'h07);
        chk("not_b", 32'(operand2), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rf_chk("not_r3", 2'd3, 8'hF8);
        chk("not_flags", 32'(flags_q), 32'h89);

        // MUL r2,r3,r3: 0xF8*0xF8 truncates to 0x40
        send(16'h3BC0);
        chk("mul_a", 32'(operand1), 32'hF8);
        chk("mul_b", 32'(operand2), 32'hF8);
        @(negedge clk);
        @(negedge clk);
        rf_chk("mul_r2", 2'd2, 8'h40);
        chk("mul_flags", 32'(flags_q), 32'h03);

        // Back-to-back stream with in_valid held high
        stream[0] = 16'h0010;
        stream[1] = 16'h0420;
        stream[2] = 16'h1440;
        base = done_cnt;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = stream[k];
            n = 0;
            while (in_ready !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("stream_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stream_dones", 32'(done_cnt - base), 32'd3);
        rf_chk("stream_r0", 2'd0, 8'h10);
        rf_chk("stream_r1", 2'd1, 8'h30);
        chk("stream_flags", 32'(flags_q), 32'h01);

        // Invalid op 1111: done N+1, sticky err, nothing written
        send(16'hF400);
        chk("inv_done", 32'(done), 32'd1);
        chk("inv_err", 32'(err), 32'd1);
        @(negedge clk);
        chk("inv_done_end", 32'(done), 32'd0);
        chk("inv_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("inv_err_hold", 32'(err), 32'd1);
        rf_chk("inv_r1", 2'd1, 8'h30);
        chk("inv_flags", 32'(flags_q), 32'h01);

        // LOADI r3=0 clears err on accept
        send(16'h0C00);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_done", 32'(done), 32'd1);
        @(negedge clk);
        rf_chk("clr_r3", 2'd3, 8'h00);

        // DIV r1,r0,r3 with r3=0
        send(16'h44C0);
`ifdef ULA_SEQ_DIV0_TRAP_EN
        chk("div0_done", 32'(done), 32'd1);
        chk("div0_err", 32'(err), 32'd1);
        @(negedge clk);
        rf_chk("div0_r1", 2'd1, 8'h30);
        chk("div0_flags", 32'(flags_q), 32'h01);
`else
        chk("div0_op", 32'(ula_operation), 32'd4);
        chk("div0_a", 32'(operand1), 32'h10);
        chk("div0_b", 32'(operand2), 32'h00);
        @(negedge clk);
        chk("div0_done", 32'(done), 32'd1);
        chk("div0_err", 32'(err), 32'd0);
        @(negedge clk);
        rf_chk("div0_r1", 2'd1, 8'hFF);
        chk("div0_flags", 32'(flags_q), 32'h84);
`endif

        // Reset during ISSUE of ADD r2: no writeback, no done
        send(16'h1840);
        chk("rsti_op", 32'(ula_operation), 32'd1);
        base = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsti_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) rf_chk("rsti_rf", 2'(i), 8'h00);
        chk("rsti_flags", 32'(flags_q), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsti_ready", 32'(in_ready), 32'd1);
        chk("rsti_err", 32'(err), 32'd0);
        chk("rsti_no_done", 32'(done_cnt - base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_sequencer.md
ULA_SEQUENCER -- requirements
Module: ula_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  instruction word present.
REQ-004 SHALL have port: in_instr  input  16  [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm (LOADI only).
REQ-005 SHALL have port: in_ready  output  1  sequencer can accept; high only in IDLE.
REQ-006 SHALL have port: ula_operation  output  4  opcode driven to ULA.
REQ-007 SHALL have ports: operand1, operand2  output  8 each  ULA operands.
REQ-008 SHALL have ports: ula_result, ula_flags  input  8 each  combinational ULA outputs.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  sticky error, cleared on next accept.
REQ-011 SHALL have port: flags_q  output  8  flags captured from last executed ULA op.
REQ-012 SHALL have ports: dbg_sel  input  2, dbg_data  output  8  combinational read of rf[dbg_sel].

Function
REQ-013 SHALL hold a 4x8 register file rf[0..3].
REQ-014 SHALL implement FSM IDLE, ISSUE, DONE; accept = in_valid && in_ready at a rising edge.
REQ-015 SHALL on accept latch op, rd, rs1-value, rs2-value, imm (operand values read from rf at the accept edge).
REQ-016 SHALL, for op 0000 (LOADI), write imm to rf[rd] at the accept edge and go IDLE->DONE.
REQ-017 SHALL, for ops 0001..1001 (ADD,SUB,MUL,DIV,MOD,AND,OR,XOR,NOT), go IDLE->ISSUE.
REQ-018 SHALL, for ops 1010..1111, set err=1, leave rf and flags_q unchanged, go IDLE->DONE.
REQ-019 SHALL, in ISSUE only, drive ula_operation=latched op, operand1=rs1 value, operand2=rs2 value (NOT: operand2=0).
REQ-020 SHALL, outside ISSUE, drive ula_operation=0000, operand1=0, operand2=0.
REQ-021 SHALL at the edge ending ISSUE write ula_result to rf[rd], ula_flags to flags_q, go DONE.
REQ-022 SHALL assert done for exactly the DONE cycle, then go DONE->IDLE unconditionally.
REQ-023 Latency: ALU op accepted at edge N -> ISSUE in cycle N+1 -> done high in cycle N+2 -> in_ready high cycle N+3; LOADI/invalid: done in cycle N+1.
REQ-024 SHALL ignore in_valid when in_ready=0 (no buffering; source must hold).
REQ-025 SHALL read operands from rf values already updated by prior writebacks (rd==rs allowed; rs1==rs2 allowed).
REQ-026 SHALL clear err on every accept before evaluating the new instruction.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge: state=IDLE, rf all 0x00, flags_q=0x00, err=0, done=0.
REQ-028 SHALL abort any in-flight instruction on reset with no writeback, including reset during ISSUE.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL support macro ULA_SEQ_DIV0_TRAP_EN.
REQ-031 With ULA_SEQ_DIV0_TRAP_EN defined: DIV/MOD with rs2 value 0x00 skips ISSUE, sets err=1, no rf/flags_q update, IDLE->DONE.
REQ-032 Without it: DIV/MOD by zero issued normally; whatever ULA returns is written back.

Verification
REQ-033 Reset, then LOADI r0=0x05, LOADI r1=0x06, ADD r2,r0,r1 (ULA model) -> dbg_sel=2 reads 0x0B; done exactly 2 cycles after ADD accept.
REQ-034 ISSUE cycle of SUB r3,r2,r0 with r2=0x0C, r0=0x05 -> ula_operation=0010, operand1=0x0C, operand2=0x05; r3=0x07 after done.
REQ-035 in_valid held high continuously with 3 queued instructions -> each accepted only when in_ready=1; no instruction lost or duplicated.
REQ-036 Op 1111 -> err=1 for cycles after accept until next accept; rf and flags_q unchanged; done pulses in cycle N+1.
REQ-037 DIV r1,r0,r3 with r3=0x00 -> with ULA_SEQ_DIV0_TRAP_EN: err=1, r1 unchanged; without: ISSUE occurs, r1=ULA result.
REQ-038 rst_n=0 asserted during ISSUE of ADD r2 -> rf all 0x00, no done pulse, in_ready=1 after release.
